// File: rtl/uart_tx_fifo_rd.sv
// Read-side consumer of an async FIFO: pops one byte per frame and serialises
// it on uart_txd as start, 8 data bits LSB first, optional even parity, stop bit(s).
module uart_tx_fifo_rd #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD      = 115_200,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_empty,
  input  logic [7:0] rd_data,
  output logic       rd_req,
  input  logic       tx_en,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             parity, parity_next;
  logic             bit_end;
  logic             txd_next, rd_req_next, tx_busy_next, tx_done_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
      uart_txd  <= 1'b1;
      rd_req    <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      parity    <= parity_next;
      uart_txd  <= txd_next;
      rd_req    <= rd_req_next;
      tx_busy   <= tx_busy_next;
      tx_done   <= tx_done_next;
    end
  end

  // Outputs are registered from the upcoming state so they line up with it.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift_reg;
    parity_next   = parity;
    bit_end       = (baud_cnt == CNT_LAST);

    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        bit_idx_next  = '0;
        if (tx_en && !rd_empty) state_next = LOAD;
      end
      LOAD: begin
        shift_next    = rd_data;
        parity_next   = ^rd_data;
        baud_cnt_next = '0;
        state_next    = START;
      end
      START: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_next = '0;
            state_next   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = STOP;
        end else begin
          baud_cnt_next = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_next = '0;
            state_next   = IDLE;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    rd_req_next  = (state_next == LOAD);
    tx_busy_next = (state_next != IDLE);
    tx_done_next = (state_next == STOP) && (bit_idx_next == STOP_LAST) &&
                   (baud_cnt_next == CNT_LAST);

    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[bit_idx_next];
      PARITY:  txd_next = parity_next;
      default: txd_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// Bench for uart_tx_fifo_rd: three instances (8N1, 8E1, 8N2) at 4 clocks per bit,
// each fed from a FIFO model and checked against a frame-timeline reference model.
module tb_uart_tx_fifo_rd;

  localparam int CPB  = 4;
  localparam int MAXN = 512;
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0;
  logic [2:0] rst, tx_en, rd_empty, rd_req, uart_txd, tx_busy, tx_done;
  logic [7:0] rd_data [3];

  logic [7:0] fifo_mem [3][16];
  int         push_cnt [3];
  int         pop_cnt  [3];
  logic [2:0] pend;

  int checks, passes, fails;

  // Signal rows: 0 txd, 1 busy, 2 done, 3 rd_req
  logic       cap_sig [4][MAXN];
  logic       exp_sig [4][MAXN];
  logic [7:0] exp_bytes [16];
  int         exp_frames, exp_pops;

  always #5 clk = ~clk;

  uart_tx_fifo_rd #(.CLK_FREQ(400), .BAUD(100), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst[0]), .rd_empty(rd_empty[0]), .rd_data(rd_data[0]),
    .rd_req(rd_req[0]), .tx_en(tx_en[0]), .uart_txd(uart_txd[0]),
    .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

  uart_tx_fifo_rd #(.CLK_FREQ(400), .BAUD(100), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst[1]), .rd_empty(rd_empty[1]), .rd_data(rd_data[1]),
    .rd_req(rd_req[1]), .tx_en(tx_en[1]), .uart_txd(uart_txd[1]),
    .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

  uart_tx_fifo_rd #(.CLK_FREQ(400), .BAUD(100), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst[2]), .rd_empty(rd_empty[2]), .rd_data(rd_data[2]),
    .rd_req(rd_req[2]), .tx_en(tx_en[2]), .uart_txd(uart_txd[2]),
    .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

  // First-word-fall-through FIFO model; a pop lands just after the edge closing LOAD.
  assign rd_empty[0] = (push_cnt[0] == pop_cnt[0]);
  assign rd_empty[1] = (push_cnt[1] == pop_cnt[1]);
  assign rd_empty[2] = (push_cnt[2] == pop_cnt[2]);
  assign rd_data[0]  = fifo_mem[0][pop_cnt[0][3:0]];
  assign rd_data[1]  = fifo_mem[1][pop_cnt[1][3:0]];
  assign rd_data[2]  = fifo_mem[2][pop_cnt[2][3:0]];

  always @(negedge clk) pend = rd_req;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++)
      if (pend[i] === 1'b1) pop_cnt[i] = pop_cnt[i] + 1;
  end

  function automatic int par_of(input int idx);
    return (idx == 1) ? 1 : 0;
  endfunction

  function automatic int stops_of(input int idx);
    return (idx == 2) ? 2 : 1;
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      0:       return "uart_txd";
      1:       return "tx_busy";
      2:       return "tx_done";
      default: return "rd_req";
    endcase
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int slot, input int par);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && par != 0) return ^b;
    return 1'b1;
  endfunction

  task automatic push_byte(input int idx, input logic [7:0] b);
    fifo_mem[idx][push_cnt[idx] % 16] = b;
    push_cnt[idx] = push_cnt[idx] + 1;
  endtask

  // Runs n sampled cycles starting at the current negedge; tx_en is high for
  // samples in [on_at, off_at). Compares against the frame timeline model.
  task automatic run_case(input int idx, input string name, input int n,
                          input int on_at, input int off_at);
    int L, t, nb, avail, base, first, dec, k;
    logic [7:0] b, d;
    L     = (10 + par_of(idx) + stops_of(idx) - 1) * CPB;
    base  = pop_cnt[idx];
    avail = push_cnt[idx] - base;
    for (int i = 0; i < n; i++) begin
      exp_sig[0][i] = 1'b1;
      exp_sig[1][i] = 1'b0;
      exp_sig[2][i] = 1'b0;
      exp_sig[3][i] = 1'b0;
    end
    t = 0; nb = 0; exp_frames = 0; exp_pops = 0;
    while (t < n && nb < avail) begin
      if (t >= on_at && t < off_at) begin
        b = fifo_mem[idx][(base + nb) % 16];
        exp_bytes[nb] = b;
        if (t + 1 < n) begin
          exp_sig[3][t+1] = 1'b1;
          exp_sig[1][t+1] = 1'b1;
        end
        for (int j = 0; j < L; j++) begin
          if (t + 2 + j < n) begin
            exp_sig[1][t+2+j] = 1'b1;
            exp_sig[0][t+2+j] = frame_bit(b, j / CPB, par_of(idx));
          end
        end
        if (t + 1 + L < n) begin
          exp_sig[2][t+1+L] = 1'b1;
          exp_frames++;
        end
        if (t + 2 <= n - 1) exp_pops++;
        nb++;
        t = t + 2 + L;
      end else begin
        t++;
      end
    end

    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      tx_en[idx] = (i >= on_at && i < off_at);
      cap_sig[0][i] = uart_txd[idx];
      cap_sig[1][i] = tx_busy[idx];
      cap_sig[2][i] = tx_done[idx];
      cap_sig[3][i] = rd_req[idx];
    end
    tx_en[idx] = 1'b0;

    for (int s = 0; s < 4; s++) begin
      first = -1;
      for (int i = 0; i < n; i++)
        if (cap_sig[s][i] !== exp_sig[s][i] && first < 0) first = i;
      checks++;
      if (first >= 0) begin
        fails++;
        $display("[TB] FAIL %s %s at cycle %0d: got %b, expected %b",
                 name, sig_name(s), first, cap_sig[s][first], exp_sig[s][first]);
      end else passes++;
    end

    checks++;
    if (pop_cnt[idx] - base !== exp_pops) begin
      fails++;
      $display("[TB] FAIL %s pop_count: got %0d, expected %0d", name, pop_cnt[idx] - base, exp_pops);
    end else passes++;

    dec = 0; k = 0;
    while (k < n) begin
      if (cap_sig[0][k] === 1'b0 && k + L <= n) begin
        for (int i = 0; i < 8; i++) d[i] = cap_sig[0][k + CPB*(i+1) + CPB/2];
        checks++;
        if (dec >= nb || d !== exp_bytes[dec]) begin
          fails++;
          $display("[TB] FAIL %s decoded_byte%0d: got %h, expected %h", name, dec, d,
                   (dec < nb) ? exp_bytes[dec] : 8'h00);
        end else passes++;
        dec++;
        k = k + L;
      end else begin
        k++;
      end
    end
    checks++;
    if (dec !== exp_frames) begin
      fails++;
      $display("[TB] FAIL %s frame_count: got %0d, expected %0d", name, dec, exp_frames);
    end else passes++;
  endtask

  task automatic test_reset;
    #1 rst = 3'b111;
    #2;
    checks++;
    if (uart_txd !== 3'b111 || rd_req !== 3'b000 || tx_busy !== 3'b000 || tx_done !== 3'b000) begin
      fails++;
      $display("[TB] FAIL reset_values: got txd=%b req=%b busy=%b done=%b, expected 111 000 000 000",
               uart_txd, rd_req, tx_busy, tx_done);
    end else passes++;
    @(negedge clk);
    rst = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_single_byte;
    int busy_len;
    push_byte(0, 8'h55);
    run_case(0, "single_55", 50, 0, NEVER);
    checks++;
    if (cap_sig[2][41] !== 1'b1 || cap_sig[2][40] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL done_after_40: got done[40]=%b done[41]=%b, expected 0 1",
               cap_sig[2][40], cap_sig[2][41]);
    end else passes++;
    busy_len = 0;
    for (int i = 0; i < 50; i++) if (cap_sig[1][i] === 1'b1) busy_len++;
    checks++;
    if (busy_len !== 41) begin
      fails++;
      $display("[TB] FAIL busy_length: got %0d, expected 41", busy_len);
    end else passes++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    push_byte(0, 8'hA5);
    push_byte(0, 8'h3C);
    run_case(0, "b2b_a5_3c", 100, 0, NEVER);
    checks++;
    if (cap_sig[0][42] !== 1'b1 || cap_sig[0][43] !== 1'b1 || cap_sig[0][44] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_gap: got %b%b%b, expected 110",
               cap_sig[0][42], cap_sig[0][43], cap_sig[0][44]);
    end else passes++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_byte(0, 8'($urandom));
    run_case(0, "b2b_random", 140, 0, NEVER);
  endtask

  task automatic test_parity;
    @(negedge clk);
    push_byte(1, 8'h07);
    run_case(1, "parity_07", 56, 0, NEVER);
    checks++;
    if (cap_sig[0][2 + 9*CPB + 2] !== 1'b1 || cap_sig[2][45] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL parity_07_bit: got parity=%b done[45]=%b, expected 1 1",
               cap_sig[0][2 + 9*CPB + 2], cap_sig[2][45]);
    end else passes++;
    @(negedge clk);
    push_byte(1, 8'h03);
    run_case(1, "parity_03", 56, 0, NEVER);
    checks++;
    if (cap_sig[0][2 + 9*CPB + 2] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL parity_03_bit: got %b, expected 0", cap_sig[0][2 + 9*CPB + 2]);
    end else passes++;
    @(negedge clk);
    push_byte(1, 8'($urandom));
    push_byte(1, 8'($urandom));
    run_case(1, "parity_random", 110, 0, NEVER);
  endtask

  task automatic test_two_stop;
    logic all_high;
    @(negedge clk);
    push_byte(2, 8'hFF);
    run_case(2, "stop2_ff", 56, 0, NEVER);
    all_high = 1'b1;
    for (int i = 38; i <= 45; i++) if (cap_sig[0][i] !== 1'b1) all_high = 1'b0;
    checks++;
    if (!all_high || cap_sig[2][45] !== 1'b1 || cap_sig[2][44] !== 1'b0 || cap_sig[1][46] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stop2_period: got high=%b done44=%b done45=%b busy46=%b, expected 1 0 1 0",
               all_high, cap_sig[2][44], cap_sig[2][45], cap_sig[1][46]);
    end else passes++;
    @(negedge clk);
    push_byte(2, 8'($urandom));
    push_byte(2, 8'($urandom));
    run_case(2, "stop2_random", 110, 0, NEVER);
  endtask

  task automatic test_flow_control;
    @(negedge clk);
    run_case(0, "empty_hold", 100, 0, NEVER);
    @(negedge clk);
    push_byte(0, 8'($urandom));
    run_case(0, "tx_en_low", 50, NEVER, NEVER);
    @(negedge clk);
    run_case(0, "tx_en_release", 50, 0, NEVER);
    @(negedge clk);
    push_byte(0, 8'($urandom));
    push_byte(0, 8'($urandom));
    run_case(0, "tx_en_drop_mid", 100, 0, 10);
    @(negedge clk);
    run_case(0, "drain_after_drop", 50, 0, NEVER);
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    push_byte(0, 8'($urandom));
    push_byte(0, 8'($urandom));
    run_case(0, "pre_reset", 19, 0, NEVER);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    checks++;
    if (uart_txd[0] !== 1'b1 || rd_req[0] !== 1'b0 || tx_busy[0] !== 1'b0 || tx_done[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_data: got txd=%b req=%b busy=%b done=%b, expected 1 0 0 0",
               uart_txd[0], rd_req[0], tx_busy[0], tx_done[0]);
    end else passes++;
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    run_case(0, "after_reset", 50, 0, NEVER);
  endtask

  initial begin
    rst    = 3'b000;
    tx_en  = 3'b000;
    checks = 0;
    passes = 0;
    fails  = 0;
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_parity;
    test_two_stop;
    test_flow_control;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
